// File: rtl/controlador_sirene_alarme_pkg.sv
// Shared state codes and helpers for the alarm siren controller.
package controlador_sirene_alarme_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_SIREN    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } estado_t;

  function automatic logic is_armed(estado_t s);
    return (s == ST_ARMED) || (s == ST_ENTRY) ||
           (s == ST_SIREN) || (s == ST_LOCKOUT);
  endfunction

  function automatic logic is_warn(estado_t s);
    return (s == ST_EXIT) || (s == ST_ENTRY);
  endfunction

endpackage

// File: rtl/controlador_sirene_alarme_contador_atraso.sv
// Loadable tick-driven down-counter for the exit/entry/siren delays.
module contador_atraso #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick_en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick_en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/controlador_sirene_alarme.sv
// Siren controller: alarm synchronizer, arm/entry/siren FSM, registered outputs.
module controlador_sirene_alarme
  import controlador_sirene_alarme_pkg::*;
#(
  parameter int EXIT_TICKS  = 4,
  parameter int ENTRY_TICKS = 8,
  parameter int SIREN_TICKS = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       alarm_i,
  input  logic       arm_i,
  input  logic       disarm_i,
  output logic       siren_o,
  output logic       beep_o,
  output logic       armed_o,
  output logic       tripped_o,
  output logic [2:0] state_o
);

  logic             sync1;
  logic             sync2;
  estado_t          st;
  estado_t          nxt;
  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             expira;

  contador_atraso #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ld),
    .value   (ld_val),
    .tick_en (tick_i),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  // Expiry is the tick that takes the counter from 1 to 0.
  assign expira = tick_i & ~cnt_zero & (cnt[CNT_W-1:1] == '0);

  always_comb begin
    nxt    = st;
    ld     = 1'b0;
    ld_val = '0;
    if (disarm_i && st != ST_DISARMED) begin
      nxt = ST_DISARMED;
      ld  = 1'b1;
    end else begin
      case (st)
        ST_DISARMED: begin
          if (arm_i && !disarm_i) begin
            nxt    = ST_EXIT;
            ld     = 1'b1;
            ld_val = CNT_W'(EXIT_TICKS);
          end
        end
        ST_EXIT: begin
          if (expira) nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (sync2) begin
            nxt    = ST_ENTRY;
            ld     = 1'b1;
            ld_val = CNT_W'(ENTRY_TICKS);
          end
        end
        ST_ENTRY: begin
          if (expira) begin
            nxt    = ST_SIREN;
            ld     = 1'b1;
            ld_val = CNT_W'(SIREN_TICKS);
          end
        end
        ST_SIREN: begin
          if (expira) nxt = sync2 ? ST_LOCKOUT : ST_ARMED;
        end
        ST_LOCKOUT: begin
          if (!sync2) nxt = ST_ARMED;
        end
        default: begin
          nxt = ST_DISARMED;
          ld  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      st        <= ST_DISARMED;
      siren_o   <= 1'b0;
      beep_o    <= 1'b0;
      armed_o   <= 1'b0;
      tripped_o <= 1'b0;
      state_o   <= '0;
    end else begin
      sync1   <= alarm_i;
      sync2   <= sync1;
      st      <= nxt;
      siren_o <= (nxt == ST_SIREN);
      armed_o <= is_armed(nxt);
      state_o <= nxt;
      if (!is_warn(nxt)) begin
        beep_o <= 1'b0;
      end else if (nxt != st) begin
        beep_o <= 1'b1;
      end else begin
        beep_o <= beep_o ^ tick_i;
      end
      if (st == ST_DISARMED && nxt == ST_EXIT) begin
        tripped_o <= 1'b0;
      end else if (st == ST_ARMED && nxt == ST_ENTRY) begin
        tripped_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_controlador_sirene_alarme.sv
// Scoreboard bench for the siren controller against a tick-level reference model.
module tb_controlador_sirene_alarme;

  localparam int EXIT_T  = 4;
  localparam int ENTRY_T = 8;
  localparam int SIREN_T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_i = 1'b0;
  logic       alarm_i = 1'b0;
  logic       arm_i = 1'b0;
  logic       disarm_i = 1'b0;
  logic       siren_o;
  logic       beep_o;
  logic       armed_o;
  logic       tripped_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  controlador_sirene_alarme #(
    .EXIT_TICKS  (EXIT_T),
    .ENTRY_TICKS (ENTRY_T),
    .SIREN_TICKS (SIREN_T),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (tick_i),
    .alarm_i   (alarm_i),
    .arm_i     (arm_i),
    .disarm_i  (disarm_i),
    .siren_o   (siren_o),
    .beep_o    (beep_o),
    .armed_o   (armed_o),
    .tripped_o (tripped_o),
    .state_o   (state_o)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       siren;
    logic       beep;
    logic       armed;
    logic       tripped;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   al_drv = 1'b0;
  bit   rst_drv = 1'b0;

  // Reference model: state by name code, elapsed ticks in the timed state,
  // and the alarm as seen two clock edges late.
  int m_st;
  int m_el;
  bit m_trip;
  bit m_beep;
  bit m_hist[$];

  function automatic int dur(int s);
    case (s)
      1:       return EXIT_T;
      3:       return ENTRY_T;
      4:       return SIREN_T;
      default: return 0;
    endcase
  endfunction

  function void m_reset();
    m_st   = 0;
    m_el   = 0;
    m_trip = 1'b0;
    m_beep = 1'b0;
    m_hist = '{1'b0, 1'b0};
  endfunction

  function void m_step(bit arm, bit dis, bit tick, bit al);
    int ns;
    bit s;
    bit done;
    s    = m_hist[1];
    ns   = m_st;
    done = 1'b0;
    if (dur(m_st) > 0 && tick) begin
      m_el++;
      done = (m_el == dur(m_st));
    end
    if (dis && m_st != 0) begin
      ns = 0;
    end else begin
      case (m_st)
        0: if (arm && !dis) begin ns = 1; m_trip = 1'b0; end
        1: if (done) ns = 2;
        2: if (s) begin ns = 3; m_trip = 1'b1; end
        3: if (done) ns = 4;
        4: if (done) ns = s ? 5 : 2;
        5: if (!s) ns = 2;
        default: ns = 0;
      endcase
    end
    if (ns != m_st) m_el = 0;
    if (ns == 1 || ns == 3) m_beep = (ns != m_st) ? 1'b1 : (m_beep ^ tick);
    else m_beep = 1'b0;
    m_st = ns;
    m_hist.push_front(al);
    void'(m_hist.pop_back());
  endfunction

  function obs_t m_obs();
    obs_t o;
    o.st      = 3'(m_st);
    o.siren   = (m_st == 4);
    o.beep    = m_beep;
    o.armed   = (m_st >= 2 && m_st <= 5);
    o.tripped = m_trip;
    return o;
  endfunction

  task automatic cycle(bit arm = 1'b0, bit dis = 1'b0);
    @(negedge clk);
    rst_n    = rst_drv;
    tick_i   = (cyc % 10 == 9);
    arm_i    = arm;
    disarm_i = dis;
    alarm_i  = al_drv;
    cyc++;
    if (!rst_n) m_reset();
    else m_step(arm, dis, tick_i, al_drv);
    exp_q.push_back(m_obs());
  endtask

  task automatic ticks(int n);
    repeat (n * 10) cycle();
  endtask

  obs_t mon_e;
  obs_t mon_a;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {state_o, siren_o, beep_o, armed_o, tripped_o};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got st=%0d sir=%b bp=%b arm=%b trp=%b want st=%0d sir=%b bp=%b arm=%b trp=%b",
                 $time, mon_a.st, mon_a.siren, mon_a.beep, mon_a.armed, mon_a.tripped,
                 mon_e.st, mon_e.siren, mon_e.beep, mon_e.armed, mon_e.tripped);
      end
    end
  end

  initial begin
    m_reset();
    rst_drv = 1'b0;
    repeat (3) cycle();
    rst_drv = 1'b1;
    cycle();

    // Full cycle: arm, exit, trip, entry, siren burst, back to armed.
    cycle(1'b1, 1'b0);
    ticks(EXIT_T + 1);
    al_drv = 1'b1;
    repeat (3) cycle();
    al_drv = 1'b0;
    ticks(ENTRY_T + SIREN_T + 2);

    // Disarm part-way through entry, then re-arm clears tripped.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    ticks(EXIT_T + 1);
    al_drv = 1'b1;
    repeat (4) cycle();
    al_drv = 1'b0;
    ticks(5);
    cycle(1'b0, 1'b1);
    ticks(2);
    cycle(1'b1, 1'b0);
    ticks(1);

    // Alarm held through the siren forces lockout, released re-arms.
    ticks(EXIT_T);
    al_drv = 1'b1;
    ticks(ENTRY_T + SIREN_T + 3);
    al_drv = 1'b0;
    ticks(2);

    // Alarm during exit is ignored; arm+disarm together stays disarmed.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    al_drv = 1'b1;
    repeat (15) cycle();
    al_drv = 1'b0;
    ticks(EXIT_T + 1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    ticks(2);

    // Randomized traffic on all inputs.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) al_drv = ~al_drv;
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end

    // Asynchronous reset in the middle of a siren burst.
    al_drv = 1'b0;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    ticks(EXIT_T + 1);
    al_drv = 1'b1;
    repeat (3) cycle();
    al_drv = 1'b0;
    ticks(ENTRY_T + 3);
    @(negedge clk);
    rst_drv = 1'b0;
    rst_n   = 1'b0;
    #1;
    vectors++;
    if ({state_o, siren_o, beep_o, armed_o, tripped_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL async_reset: got st=%0d sir=%b bp=%b arm=%b trp=%b want all 0",
               state_o, siren_o, beep_o, armed_o, tripped_o);
    end
    repeat (2) cycle();
    rst_drv = 1'b1;
    cycle();
    cycle(1'b1, 1'b0);
    ticks(2);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
